// File: rtl/chimpo_io_pkg.sv
// Shared constants and FSM state encoding for the Chimpo front-end input loader.
package chimpo_io_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NIB_W_DEF  = 4;
  localparam int NIBBLES    = DATA_W_DEF / NIB_W_DEF;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
endpackage

// File: rtl/input_loader_btn_conditioner.sv
// One raw button -> 2-flop sync -> debounce -> registered one-cycle rising-edge pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic          deb, deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      // cnt tracks consecutive disagreeing samples; the last one flips the level
      if (sync[1] != deb) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      deb_q <= deb;
      rise  <= deb & ~deb_q;
    end
  end
endmodule

// File: rtl/input_loader.sv
// Front end of the Chimpo Datapath: conditions buttons, assembles operands from
// switch nibbles, and hands them over with a start pulse / done handshake.
module input_loader
  import chimpo_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int NIB_W           = NIB_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              shift,
  input  logic              calculate,
  input  logic [NIB_W-1:0]  switch,
  input  logic              done,
  output logic [DATA_W-1:0] input_value,
  output logic              start,
  output logic              ready,
  output logic [CNT_W-1:0]  nibble_count
);
  localparam int NIBS = DATA_W / NIB_W;

  logic             shift_rise, calc_rise;
  logic [NIB_W-1:0] sw_s1, sw_s2;
  state_t           state, state_nx;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shift (
    .CLK(CLK), .reset(reset), .btn(shift), .rise(shift_rise)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_calc (
    .CLK(CLK), .reset(reset), .btn(calculate), .rise(calc_rise)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (calc_rise) state_nx = START;
      end
      START:   state_nx = RUN;
      RUN:     if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // start is registered alongside the IDLE->START transition so it lines up with START
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      input_value  <= '0;
      start        <= 1'b0;
      nibble_count <= '0;
    end else begin
      start <= (state == IDLE) && calc_rise;
      case (state)
        IDLE: begin
          if (shift_rise) begin
            if (nibble_count == '0) input_value <= DATA_W'(sw_s2);
            else                    input_value <= {input_value[DATA_W-NIB_W-1:0], sw_s2};
            if (nibble_count != CNT_W'(NIBS)) nibble_count <= nibble_count + CNT_W'(1);
          end
        end
        START:   nibble_count <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_input_loader.sv
// Scoreboarded random/directed bench for input_loader; start pulses are checked
// by an independent monitor against values queued by the stimulus.
module tb_input_loader;
  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        shift = 1'b0, calculate = 1'b0, done = 1'b0;
  logic [3:0]  switch = 4'd0;
  logic [15:0] input_value;
  logic        start, ready;
  logic [2:0]  nibble_count;

  int errs = 0, checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_val = 16'd0;
  int          m_cnt = 0;
  logic        prev_start = 1'b0;

  input_loader #(.DEBOUNCE_CYCLES(3), .DATA_W(16), .NIB_W(4)) dut (
    .CLK(CLK), .reset(reset), .shift(shift), .calculate(calculate), .switch(switch),
    .done(done), .input_value(input_value), .start(start), .ready(ready),
    .nibble_count(nibble_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reference: the operand is the last nibbles entered since the last start (max 4),
  // with the first nibble after a start replacing the whole value.
  function automatic void m_shift(input logic [3:0] nib);
    if (m_cnt == 0) m_val = {12'd0, nib};
    else            m_val = 16'((32'(m_val) * 16 + 32'(nib)) % 65536);
    if (m_cnt < 4) m_cnt++;
  endfunction

  task automatic chk_model(input string n);
    chk({n, "_value"}, 32'(input_value), 32'(m_val));
    chk({n, "_count"}, 32'(nibble_count), 32'(m_cnt));
  endtask

  task automatic press_shift(input logic [3:0] nib, input int hold);
    switch = nib;
    shift  = 1'b1;
    cyc(hold);
    shift = 1'b0;
    cyc(10);
    m_shift(nib);
  endtask

  task automatic glitch(input int len);
    shift = 1'b1;
    cyc(len);
    shift = 1'b0;
    cyc(10);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(1);
  endtask

  // Ends in RUN (or IDLE if do_done); optionally tries a shift while busy.
  task automatic press_calc(input bit run_shift, input bit do_done);
    exp_q.push_back(m_val);
    calculate = 1'b1;
    cyc(4);
    calculate = 1'b0;
    cyc(8);
    m_cnt = 0;
    chk("run_ready", 32'(ready), 32'd0);
    chk_model("run");
    if (run_shift) begin
      switch = 4'($urandom_range(0, 15));
      shift  = 1'b1;
      cyc(4);
      shift = 1'b0;
      cyc(10);
      chk_model("run_shift_ignored");
      chk("run_ready_hold", 32'(ready), 32'd0);
    end
    if (do_done) begin
      pulse_done();
      chk("done_ready", 32'(ready), 32'd1);
    end
  endtask

  // Monitor: every start pulse must match the oldest queued operand, last one cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (start === 1'b1) begin
        chk("start_width", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_start: got start=1 with value %0h, required no start", input_value);
        end else begin
          chk("start_value", 32'(input_value), 32'(exp_q.pop_front()));
          chk("start_ready", 32'(ready), 32'd0);
        end
      end
      prev_start = start;
    end
  end

  initial begin
    // Reset held with inputs toggling
    for (int i = 0; i < 8; i++) begin
      shift = i[0]; calculate = i[1]; switch = 4'($urandom_range(0, 15)); done = i[0];
      cyc(1);
      chk("rst_value", 32'(input_value), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_count", 32'(nibble_count), 32'd0);
    end
    shift = 0; calculate = 0; done = 0; switch = 0;
    cyc(1);
    reset = 1'b1;
    cyc(15);
    chk_model("post_reset");
    chk("post_reset_ready", 32'(ready), 32'd1);

    // Latency: load lands 7 edges after the raw rise (edge pulse at 6)
    switch = 4'd8;
    shift  = 1'b1;
    cyc(5);
    shift = 1'b0;
    cyc(1);
    chk("lat_not_yet", 32'(input_value), 32'd0);
    cyc(1);
    chk("lat_loaded", 32'(input_value), 32'h0008);
    chk("lat_count", 32'(nibble_count), 32'd1);
    cyc(10);
    m_shift(4'd8);
    chk_model("one_shift");

    // Five presses saturate the count and drop the oldest nibble
    for (int i = 1; i <= 5; i++) press_shift(4'(i), 3 + i % 3);
    chk("sat_value", 32'(input_value), 32'h2345);
    chk("sat_count", 32'(nibble_count), 32'd4);

    glitch(2);
    chk_model("glitch2");
    glitch(1);
    chk_model("glitch1");

    press_calc(1'b0, 1'b1);
    press_shift(4'hA, 4);
    press_shift(4'h5, 3);
    chk("a5_value", 32'(input_value), 32'h00A5);
    press_calc(1'b1, 1'b1);
    press_shift(4'h7, 5);
    chk("after_run_value", 32'(input_value), 32'h0007);
    press_calc(1'b0, 1'b1);
    press_calc(1'b0, 1'b1);  // repeat calculation with nothing loaded

    // Shift and calculate together: start must see the new nibble
    press_shift(4'h1, 4);
    press_shift(4'h2, 4);
    switch = 4'h3;
    m_shift(4'h3);
    exp_q.push_back(m_val);
    chk("simul_expect", 32'(m_val), 32'h0123);
    shift = 1'b1; calculate = 1'b1;
    cyc(4);
    shift = 1'b0; calculate = 1'b0;
    cyc(10);
    m_cnt = 0;
    chk_model("simul_run");
    pulse_done();

    // done while idle is ignored
    pulse_done();
    chk("idle_done_ready", 32'(ready), 32'd1);
    chk_model("idle_done");

    // Randomized operation mix
    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      press_shift(4'($urandom_range(0, 15)), $urandom_range(3, 6));
      else if (r <= 7) glitch($urandom_range(1, 2));
      else if (r == 8) press_calc(1'($urandom_range(0, 1)), 1'b1);
      else             pulse_done();
      chk_model("rand");
      chk("rand_ready", 32'(ready), 32'd1);
    end

    // Reset in RUN: immediate return to reset values, no start afterwards
    press_shift(4'h9, 4);
    press_calc(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rrun_ready", 32'(ready), 32'd1);
    chk("rrun_value", 32'(input_value), 32'd0);
    chk("rrun_count", 32'(nibble_count), 32'd0);
    chk("rrun_start", 32'(start), 32'd0);
    cyc(3);
    reset = 1'b1;
    m_val = 16'd0;
    m_cnt = 0;
    cyc(20);
    chk_model("rrun_after");
    chk("rrun_after_ready", 32'(ready), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
